writeback_unit: RTL and testbench
=================================

Name: writeback_unit

Overview:
- Write-back stage of the pipelined MIPS-32 core; the sole producer of the register file write port (RegWrite/WriteReg/WriteData).
- Accepts retired results from the MEM/WB boundary over a valid/ready handshake and selects ALU result or load data.
- Buffers results in a small FIFO and drains at most one register write per cycle.
- Exposes two forwarding lookups so ID/EX can see values not yet committed to the register file.

Parameters:
DEPTH, 2, pending-write FIFO entries (power of two, >=2)
WIDTH, 32, data width

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
flush  input  1  synchronous: discard all FIFO entries
wb_hold  input  1  suppress draining this cycle
in_valid  input  1  MEM/WB result present
in_ready  output  1  unit can accept; combinational, = (count<DEPTH) && !flush
in_reg_write  input  1  instruction writes a register
in_mem_to_reg  input  1  1: write in_mem_data; 0: write in_alu_result
in_dest  input  5  destination register
in_alu_result  input  WIDTH  ALU result
in_mem_data  input  WIDTH  load data
RegWrite  output  1  register file write enable, registered
WriteReg  output  5  register file write address, registered
WriteData  output  WIDTH  register file write data, registered
fwd_reg1  input  5  lookup address 1
fwd_hit1  output  1  pending write to fwd_reg1 exists
fwd_data1  output  WIDTH  youngest pending value for fwd_reg1
fwd_reg2  input  5  lookup address 2
fwd_hit2  output  1  as fwd_hit1, for fwd_reg2
fwd_data2  output  WIDTH  as fwd_data1, for fwd_reg2
retire_count  output  32  see Optional Feature
hold_cycles  output  32  see Optional Feature

Behaviour:
- Reset (rst_n low, asynchronous): count, read and write pointers = 0; RegWrite=0; WriteReg=0; WriteData=0; counters=0. in_ready=1 once flush is low.
- Accept: handshake on a rising edge with in_valid && in_ready.
  - If in_reg_write=1 and in_dest!=0: enqueue {in_dest, in_mem_to_reg ? in_mem_data : in_alu_result}. The mux is resolved at enqueue.
  - Otherwise the instruction is accepted and dropped. Writes to $zero never reach the register file.
- Drain: at each rising edge, if count>0 and !wb_hold, pop the head into WriteReg/WriteData and set RegWrite<=1. Otherwise RegWrite<=0, and WriteReg/WriteData hold their values.
- RegWrite is high for exactly one cycle per popped entry.
- Latency with an empty FIFO and no hold: accepted at edge E0, RegWrite high from E1 to E2, register file commits at E2.
- Throughput: one write per cycle sustained.
- Simultaneous push and pop: count unchanged. Full FIFO: in_ready=0, so push and pop never happen together at DEPTH.
- Pointers wrap modulo DEPTH.
- flush: at that edge count and pointers go to 0, and no push or pop occurs. The output register still updates to RegWrite<=0. A write already on RegWrite completes.
- Reset mid-drain: the pending entry is lost and RegWrite drops immediately.
- Forwarding (combinational): priority is youngest FIFO entry, then older FIFO entries, then the output register while RegWrite=1.
  - hit=0 and data=0 when there is no match or the address is 0.
  - Entries popped and already committed are not visible.
- Effective state: EMPTY (count=0), PARTIAL, FULL (count=DEPTH).
  - EMPTY to PARTIAL on push.
  - PARTIAL to FULL on push without pop.
  - Any state to EMPTY on flush.
  - FULL to PARTIAL on pop.

Optional Feature:
- Macro WB_STATS_EN.
- Defined:
  - retire_count increments on every accepted handshake, including dropped ones.
  - hold_cycles increments each cycle with wb_hold=1 and count>0.
  - Both wrap at 2^32, reset to 0, and are not cleared by flush.
- Undefined: both outputs are constant 0 and no counter logic is built.

Test Plan:
- Reset then in_dest=8, alu=0x0000001E, mem_to_reg=0 -> one cycle later RegWrite=1, WriteReg=8, WriteData=0x1E; next cycle RegWrite=0.
- Load with mem_to_reg=1, mem=0xDEADBEEF, alu=0x4, dest=9 -> WriteData=0xDEADBEEF; dest=0 or reg_write=0 -> no RegWrite pulse; retire_count still increments (WB_STATS_EN).
- wb_hold=1, push dest=10 then dest=11 -> in_ready=0 after 2 pushes; fwd_reg1=10 -> hit1=1; release hold -> writes 10 then 11 on consecutive cycles.
- Push dest=12 data 5, then dest=12 data 7, with hold -> fwd_reg2=12 returns 7 (youngest); fwd_reg1=0 -> hit1=0.
- FIFO holding 2 entries, assert flush -> count 0, no further RegWrite, in_ready=0 during flush and 1 after.
- Reset asserted asynchronously between edges while RegWrite=1 -> RegWrite, WriteReg and WriteData go to 0 immediately; hold_cycles=0.

Source files
------------

// File: rtl/writeback_unit.sv
// Write-back stage: buffers retired MEM/WB results in a small FIFO and drains one
// register-file write per cycle, with two forwarding lookups. Optional counters: WB_STATS_EN.
module writeback_unit #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             wb_hold,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_reg_write,
  input  logic             in_mem_to_reg,
  input  logic [4:0]       in_dest,
  input  logic [WIDTH-1:0] in_alu_result,
  input  logic [WIDTH-1:0] in_mem_data,
  output logic             RegWrite,
  output logic [4:0]       WriteReg,
  output logic [WIDTH-1:0] WriteData,
  input  logic [4:0]       fwd_reg1,
  output logic             fwd_hit1,
  output logic [WIDTH-1:0] fwd_data1,
  input  logic [4:0]       fwd_reg2,
  output logic             fwd_hit2,
  output logic [WIDTH-1:0] fwd_data2,
  output logic [31:0]      retire_count,
  output logic [31:0]      hold_cycles
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  typedef enum logic [1:0] {ST_EMPTY, ST_PARTIAL, ST_FULL} fifo_state_t;

  fifo_state_t      state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [PW-1:0]    rd_ptr, wr_ptr;
  logic [4:0]       mem_dest [DEPTH];
  logic [WIDTH-1:0] mem_data [DEPTH];
  logic             push, pop;

  // Handshake: a transfer happens on a rising edge where in_valid && in_ready.
  // Accepted instructions that write nothing (or write $zero) are simply dropped.
  assign in_ready = (state_q != ST_FULL) && !flush;
  assign push     = in_valid && in_ready && in_reg_write && (in_dest != 5'd0);
  assign pop      = (state_q != ST_EMPTY) && !wb_hold && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    count_d = count_q;
    state_d = state_q;
    if (flush) begin
      count_d = '0;
      state_d = ST_EMPTY;
    end else begin
      count_d = count_q + CW'(push) - CW'(pop);
      if (count_d == '0)              state_d = ST_EMPTY;
      else if (count_d == CW'(DEPTH)) state_d = ST_FULL;
      else                            state_d = ST_PARTIAL;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      RegWrite  <= 1'b0;
      WriteReg  <= '0;
      WriteData <= '0;
    end else begin
      RegWrite <= pop;
      if (pop) begin
        WriteReg  <= mem_dest[rd_ptr];
        WriteData <= mem_data[rd_ptr];
      end
      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop)  rd_ptr <= rd_ptr + PW'(1);
      end
    end
  end

  // Load/ALU selection is resolved here so entries hold final values.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_dest[wr_ptr] <= in_dest;
      mem_data[wr_ptr] <= in_mem_to_reg ? in_mem_data : in_alu_result;
    end
  end

  // Walk oldest to youngest so the youngest match wins; output register is lowest priority.
  function automatic logic [WIDTH:0] lookup(input logic [4:0] addr);
    logic [WIDTH:0] r;
    logic [PW-1:0]  idx;
    r = '0;
    if (addr != 5'd0) begin
      if (RegWrite && (WriteReg == addr)) r = {1'b1, WriteData};
      for (int i = 0; i < DEPTH; i++) begin
        idx = rd_ptr + PW'(i);
        if ((CW'(i) < count_q) && (mem_dest[idx] == addr)) r = {1'b1, mem_data[idx]};
      end
    end
    return r;
  endfunction

  always_comb begin
    {fwd_hit1, fwd_data1} = lookup(fwd_reg1);
    {fwd_hit2, fwd_data2} = lookup(fwd_reg2);
  end

`ifdef WB_STATS_EN
  logic [31:0] retire_q, hold_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retire_q <= '0;
      hold_q   <= '0;
    end else begin
      if (in_valid && in_ready)                retire_q <= retire_q + 32'd1;
      if (wb_hold && (state_q != ST_EMPTY))    hold_q   <= hold_q + 32'd1;
    end
  end

  assign retire_count = retire_q;
  assign hold_cycles  = hold_q;
`else
  assign retire_count = '0;
  assign hold_cycles  = '0;
`endif

endmodule

// File: tb/tb_writeback_unit.sv
// Scoreboard bench for writeback_unit: a queue-based reference model predicts each
// register write, and an independent monitor checks every RegWrite pulse.
module tb_writeback_unit;

  localparam int DEPTH = 2;
  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             flush = 1'b0, wb_hold = 1'b0;
  logic             in_valid = 1'b0, in_reg_write = 1'b0, in_mem_to_reg = 1'b0;
  logic [4:0]       in_dest = '0;
  logic [WIDTH-1:0] in_alu_result = '0, in_mem_data = '0;
  logic             in_ready;
  logic             RegWrite;
  logic [4:0]       WriteReg;
  logic [WIDTH-1:0] WriteData;
  logic [4:0]       fwd_reg1 = '0, fwd_reg2 = '0;
  logic             fwd_hit1, fwd_hit2;
  logic [WIDTH-1:0] fwd_data1, fwd_data2;
  logic [31:0]      retire_count, hold_cycles;

  writeback_unit #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .wb_hold(wb_hold),
    .in_valid(in_valid), .in_ready(in_ready), .in_reg_write(in_reg_write),
    .in_mem_to_reg(in_mem_to_reg), .in_dest(in_dest),
    .in_alu_result(in_alu_result), .in_mem_data(in_mem_data),
    .RegWrite(RegWrite), .WriteReg(WriteReg), .WriteData(WriteData),
    .fwd_reg1(fwd_reg1), .fwd_hit1(fwd_hit1), .fwd_data1(fwd_data1),
    .fwd_reg2(fwd_reg2), .fwd_hit2(fwd_hit2), .fwd_data2(fwd_data2),
    .retire_count(retire_count), .hold_cycles(hold_cycles)
  );

  // clock
  always #5 clk = ~clk;

  // reference model state
  logic [36:0] mq[$];      // pending writes {dest, data}, oldest first
  logic [36:0] exp_q[$];   // writes expected on the register-file port, in order
  logic        m_rw = 1'b0;
  logic [36:0] m_out = '0;
  logic [31:0] m_retire = '0, m_hold = '0;
  bit          mon_en = 1'b0;
  int          n_vec = 0, n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [32:0] model_fwd(input logic [4:0] r);
    if (r == 5'd0) return '0;
    for (int i = mq.size() - 1; i >= 0; i--)
      if (mq[i][36:32] == r) return {1'b1, mq[i][31:0]};
    if (m_rw && (m_out[36:32] == r)) return {1'b1, m_out[31:0]};
    return '0;
  endfunction

  // monitor: every pulse must match the next expected write; no expected write may be skipped
  always @(negedge clk) begin
    logic [36:0] e;
    if (rst_n && mon_en) begin
      if (RegWrite) begin
        if (exp_q.size() == 0) check("spurious_write", RegWrite, 1'b0);
        else begin
          e = exp_q.pop_front();
          check("write_reg", WriteReg, e[36:32]);
          check("write_data", WriteData, e[31:0]);
        end
      end else if (exp_q.size() > 0) begin
        check("missing_write", RegWrite, 1'b1);
        exp_q.delete();
      end
    end
  end

  // driver: called just after a falling edge, returns just after the next falling edge
  task automatic step(input logic v, input logic rw, input logic m2r, input logic [4:0] d,
                      input logic [31:0] alu, input logic [31:0] mem, input logic hold,
                      input logic fl, input logic [4:0] r1, input logic [4:0] r2,
                      input logic kill);
    logic        exp_rdy;
    logic [32:0] f;
    logic [36:0] e;
    in_valid = v; in_reg_write = rw; in_mem_to_reg = m2r; in_dest = d;
    in_alu_result = alu; in_mem_data = mem; wb_hold = hold; flush = fl;
    fwd_reg1 = r1; fwd_reg2 = r2;
    #1;
    exp_rdy = (mq.size() < DEPTH) && !fl;
    check("in_ready", in_ready, exp_rdy);
    f = model_fwd(r1);
    check("fwd_hit1", fwd_hit1, f[32]);
    check("fwd_data1", fwd_data1, f[31:0]);
    f = model_fwd(r2);
    check("fwd_hit2", fwd_hit2, f[32]);
    check("fwd_data2", fwd_data2, f[31:0]);
    @(posedge clk);
    if (v && exp_rdy) m_retire++;
    if (hold && mq.size() > 0) m_hold++;
    if (fl) begin
      mq.delete();
      m_rw = 1'b0;
    end else begin
      if (mq.size() > 0 && !hold) begin
        e = mq.pop_front();
        exp_q.push_back(e);
        m_rw = 1'b1;
        m_out = e;
      end else m_rw = 1'b0;
      if (v && exp_rdy && rw && d != 5'd0) mq.push_back({d, m2r ? mem : alu});
    end
    if (kill) begin
      #2;
      check("rw_before_reset", RegWrite, m_rw);
      rst_n = 1'b0;
      #1;
      check("rst_regwrite", RegWrite, 1'b0);
      check("rst_writereg", WriteReg, 5'd0);
      check("rst_writedata", WriteData, 32'd0);
      check("rst_hold_cycles", hold_cycles, 32'd0);
      mq.delete(); exp_q.delete();
      m_rw = 1'b0; m_retire = '0; m_hold = '0;
      @(negedge clk);
      #2 rst_n = 1'b1;
    end else begin
      @(negedge clk);
`ifdef WB_STATS_EN
      check("retire_count", retire_count, m_retire);
      check("hold_cycles", hold_cycles, m_hold);
`else
      check("retire_count", retire_count, 32'd0);
      check("hold_cycles", hold_cycles, 32'd0);
`endif
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_regwrite", RegWrite, 1'b0);
    check("reset_writereg", WriteReg, 5'd0);
    check("reset_writedata", WriteData, 32'd0);
    check("reset_retire", retire_count, 32'd0);
    check("reset_ready", in_ready, 1'b1);
    rst_n = 1'b1;
    mon_en = 1'b1;

    // basic ALU write, then load, then dropped writes
    step(1, 1, 0, 8, 32'h1E, 32'h0, 0, 0, 8, 0, 0);
    step(1, 1, 1, 9, 32'h4, 32'hDEADBEEF, 0, 0, 8, 9, 0);
    step(1, 1, 0, 0, 32'h55, 32'h0, 0, 0, 9, 0, 0);
    step(1, 0, 0, 3, 32'h66, 32'h0, 0, 0, 0, 3, 0);
    idle(2);

    // hold fills the FIFO, then releases in order
    step(1, 1, 0, 10, 32'hA0, 32'h0, 1, 0, 10, 0, 0);
    step(1, 1, 0, 11, 32'hB0, 32'h0, 1, 0, 10, 11, 0);
    step(1, 1, 0, 12, 32'hC0, 32'h0, 1, 0, 10, 11, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 10, 11, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 10, 11, 0);
    idle(1);

    // youngest-wins forwarding, then flush of a full FIFO
    step(1, 1, 0, 12, 32'd5, 32'h0, 1, 0, 12, 0, 0);
    step(1, 1, 0, 12, 32'd7, 32'h0, 1, 0, 12, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1, 0, 0, 12, 0);
    step(1, 1, 0, 13, 32'd9, 32'h0, 1, 1, 12, 12, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 12, 13, 0);
    idle(2);

    // asynchronous reset while a write is on the port
    step(1, 1, 0, 14, 32'h77, 32'h0, 1, 0, 14, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 14, 0, 1);
    idle(2);

    // randomized traffic
    for (int i = 0; i < 2000; i++) begin
      step($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 8, $urandom_range(0, 1),
           5'($urandom_range(0, 7)), $urandom, $urandom,
           $urandom_range(0, 9) < 3, $urandom_range(0, 99) < 3,
           5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 0);
    end
    idle(DEPTH + 3);
    check("drain_left", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
